dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
Controller that sequences one DSP48A1-style multiply-accumulate slice through an N-sample dot product. It accepts samples over a valid/ready handshake and drives per-stage clock enables, so pipeline bubbles never accumulate. It also drives OPMODE and the P-register synchronous reset, and signals when the accumulated result in P is valid. It sits between the sample source and the slice's registered datapath (input, multiplier and P stages).

Parameters:
CNT_W, 10, width of sample-count length field (max N = 2^CNT_W-1)
PIPE_LAT, 4, number of registered slice stages from input register to P register inclusive (>=2)
OPMODE_ACC, 8'h09, OPMODE driven while accumulating (X=M, Z=P)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  begin a job; sampled only in IDLE
len  in  CNT_W  number of samples for the job, captured with start
abort  in  1  synchronous job cancel
in_valid  in  1  source has a sample on the slice A/B inputs
in_ready  out  1  sequencer accepts the sample this cycle
stage_ce  out  PIPE_LAT  per-stage clock enable; bit 0 = A/B input registers, bit PIPE_LAT-1 = P register
opmode  out  8  slice OPMODE
rstp  out  1  synchronous reset pulse to the slice P register
busy  out  1  job in progress (state != IDLE)
result_valid  out  1  one-cycle pulse: P holds the final sum
done  out  1  one-cycle pulse: job finished (normal or len=0)

Behaviour:
- Reset (reset_n=0, async): state IDLE, counter 0, vpipe 0. All outputs 0.
- States: IDLE, CLEAR, FEED, DRAIN, FIN.
- IDLE:
  - start=1 and len!=0: capture len into remaining counter; go to CLEAR.
  - start=1 and len==0: done=1 next cycle (registered); remain IDLE; result_valid stays 0.
  - opmode=0.
- CLEAR: exactly one cycle. rstp=1, opmode=OPMODE_ACC. Go to FEED.
- FEED:
  - in_ready=1 and opmode=OPMODE_ACC.
  - A beat is in_valid&in_ready. stage_ce[0]=beat (combinational).
  - Each beat decrements remaining. The beat that takes remaining to 0 moves the state to DRAIN.
  - in_valid=0 creates a bubble: no stage_ce[0], and the bubble propagates.
- Stage enables: vpipe is a PIPE_LAT-1 bit shift register of beats. stage_ce[k]=vpipe[k-1] for k>=1.
- Latency: beat in cycle t updates P at the end of cycle t+PIPE_LAT-1.
- DRAIN:
  - in_ready=0, opmode=OPMODE_ACC.
  - Stay until vpipe is all zero (no enable pending), then go to FIN.
- FIN: one cycle. result_valid=1, done=1, all stage_ce=0 so P holds its value. Go to IDLE. P is not cleared until the next job's CLEAR.
- busy=1 in CLEAR, FEED, DRAIN and FIN.
- start outside IDLE: ignored, and len is not recaptured.
- abort in CLEAR, FEED or DRAIN:
  - Next state IDLE, with vpipe, remaining and stage_ce cleared immediately.
  - rstp=1 for that one cycle.
  - No done or result_valid.
  - abort takes priority over a simultaneous beat, and that beat is not accepted (in_ready forced 0).
- abort in IDLE or FIN: no effect.
- reset_n asserted mid-job: immediate return to reset values. No done.
- remaining counter: CNT_W bits, decrement only, never wraps; FEED exits at 1->0.

Decomposition:
- Shared package dsp_ctrl_pkg holds:
  - state encoding typedef/localparams (IDLE, CLEAR, FEED, DRAIN, FIN);
  - OPMODE constants (OPMODE_ZERO=8'h00, OPMODE_ACC=8'h09);
  - default PIPE_LAT.
- One natural sub-module: dsp_stage_valid_pipe, the PIPE_LAT-1 bit enable shift register with synchronous flush and async active-low reset.
- FSM and counter stay in the top.

Test Plan:
1. PIPE_LAT=4. start/len=3 at cycle 0, in_valid held 1 -> CLEAR cycle 1 (rstp=1); in_ready cycles 2-4; stage_ce[3] cycles 5-7; result_valid=done=1 cycle 8; P = sum of three products.
2. len=3 with in_valid=0 in cycle 3 -> beats at cycles 2, 4, 5; bubble visible as stage_ce[k] low at cycle 3+k; result_valid at cycle 9; no extra accumulation.
3. start with len=0 -> done=1 one cycle later, busy never 1, result_valid=0, stage_ce all 0.
4. abort asserted with in_valid=1 during second FEED beat of len=5 -> that beat not accepted, rstp=1 that cycle, next cycle IDLE with busy=0, stage_ce=0, no done; a following job of len=2 gives the correct fresh sum.
5. start pulsed with len=7 during DRAIN of a len=2 job -> ignored; first job finishes normally; in_ready stays 0 after FIN.
6. reset_n pulled low asynchronously mid-FEED -> all outputs 0 immediately, state IDLE after release, next job runs correctly.

Source files
------------

// File: rtl/dsp_ctrl_pkg.sv
// Shared constants for the DSP48A1 MAC sequencer: state encoding, OPMODE values
// and default pipeline depth.
package dsp_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_CLEAR = 3'd1;
    localparam state_t S_FEED  = 3'd2;
    localparam state_t S_DRAIN = 3'd3;
    localparam state_t S_FIN   = 3'd4;

    localparam logic [7:0] OPMODE_ZERO = 8'h00;
    localparam logic [7:0] OPMODE_ACC  = 8'h09;

    localparam int unsigned PIPE_LAT_DEF = 4;
    localparam int unsigned CNT_W_DEF    = 10;

endpackage

// File: rtl/dsp_stage_valid_pipe.sv
// Shift register of accepted beats; bit k drives the clock enable of slice stage k+1.
module dsp_stage_valid_pipe #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         shift_in,
    input  logic         flush,
    output logic [W-1:0] vpipe
);

    // Shift expressed arithmetically so a single-bit pipe needs no special case.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vpipe <= '0;
        end else if (flush) begin
            vpipe <= '0;
        end else begin
            vpipe <= (vpipe << 1) | W'(shift_in);
        end
    end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1-style MAC slice through an N-sample dot product, gating each
// pipeline stage with its own enable so input bubbles never accumulate into P.
module dsp_mac_sequencer #(
    parameter int unsigned CNT_W      = dsp_ctrl_pkg::CNT_W_DEF,
    parameter int unsigned PIPE_LAT   = dsp_ctrl_pkg::PIPE_LAT_DEF,
    parameter logic [7:0]  OPMODE_ACC = dsp_ctrl_pkg::OPMODE_ACC
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    len,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [PIPE_LAT-1:0] stage_ce,
    output logic [7:0]          opmode,
    output logic                rstp,
    output logic                busy,
    output logic                result_valid,
    output logic                done
);

    import dsp_ctrl_pkg::*;

    localparam int unsigned VW = PIPE_LAT - 1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic             done_zero;
    logic [VW-1:0]    vpipe;
    logic [VW-1:0]    vpipe_shifted;
    logic             active;
    logic             kill;
    logic             beat;
    logic             drain_empty;
    logic             start_job;

    assign active    = (state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN);
    assign kill      = abort && active;
    assign start_job = (state == S_IDLE) && start && (len != '0);

    assign in_ready = (state == S_FEED) && !abort;
    assign beat     = in_valid && in_ready;

    // DRAIN may leave as soon as the enable about to shift out is the last one pending.
    assign vpipe_shifted = vpipe << 1;
    assign drain_empty   = (vpipe_shifted == '0);

    assign stage_ce     = kill ? '0 : {vpipe, beat};
    assign opmode       = active ? OPMODE_ACC : OPMODE_ZERO;
    assign rstp         = (state == S_CLEAR) || kill;
    assign busy         = (state != S_IDLE);
    assign result_valid = (state == S_FIN);
    assign done         = result_valid || done_zero;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_job) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_FEED;
            S_FEED:  if (beat && remaining == CNT_W'(1)) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_empty) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (kill) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            done_zero <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_zero <= (state == S_IDLE) && start && (len == '0);
            if (kill) begin
                remaining <= '0;
            end else if (start_job) begin
                remaining <= len;
            end else if (beat && remaining != '0) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    dsp_stage_valid_pipe #(
        .W(VW)
    ) u_vpipe (
        .clk     (clk),
        .reset_n (reset_n),
        .shift_in(beat),
        .flush   (kill),
        .vpipe   (vpipe)
    );

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench: job-level reference model plus a behavioural MAC slice
// driven by the DUT enables, checked every cycle.
module tb_dsp_mac_sequencer;

    localparam int PL = 4;
    localparam int CW = 10;

    localparam int PH_IDLE  = 0;
    localparam int PH_CLEAR = 1;
    localparam int PH_FEED  = 2;
    localparam int PH_DRAIN = 3;
    localparam int PH_FIN   = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] len = '0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PL-1:0] stage_ce;
    logic [7:0]    opmode;
    logic          rstp;
    logic          busy;
    logic          result_valid;
    logic          done;
    logic [7:0]    a = '0;
    logic [7:0]    b = '0;

    int n_checks = 0;
    int n_fail = 0;
    int n_rv = 0;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(
        .CNT_W     (CW),
        .PIPE_LAT  (PL),
        .OPMODE_ACC(8'h09)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .len         (len),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .stage_ce    (stage_ce),
        .opmode      (opmode),
        .rstp        (rstp),
        .busy        (busy),
        .result_valid(result_valid),
        .done        (done)
    );

    // Behavioural slice: stage 0 registers the product, middle stages forward it, last stage accumulates.
    logic [15:0] pv [PL-1];
    logic [31:0] p;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < PL - 1; k++) pv[k] <= '0;
            p <= '0;
        end else begin
            if (stage_ce[0]) pv[0] <= 16'(a) * 16'(b);
            for (int k = 1; k < PL - 1; k++) if (stage_ce[k]) pv[k] <= pv[k-1];
            if (rstp) p <= '0;
            else if (stage_ce[PL-1]) p <= p + 32'(pv[PL-2]);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: job phases, accepted-beat times and the expected dot product.
    int          m_phase = PH_IDLE;
    int          m_rem = 0;
    int          m_last = 0;
    int          cyc = 0;
    int          bq[$];
    bit          m_dz = 0;
    int unsigned m_sum = 0;

    always begin : cmp
        logic [PL-1:0] e_ce;
        bit e_ready, e_beat, e_kill, act;
        @(negedge clk);
        #2;
        e_beat = 0;
        e_kill = 0;
        if (!reset_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_stage_ce", stage_ce, 0);
            chk("rst_opmode", opmode, 0);
            chk("rst_rstp", rstp, 0);
            chk("rst_busy", busy, 0);
            chk("rst_result_valid", result_valid, 0);
            chk("rst_done", done, 0);
        end else begin
            act = (m_phase == PH_CLEAR) || (m_phase == PH_FEED) || (m_phase == PH_DRAIN);
            e_kill = abort && act;
            e_ready = (m_phase == PH_FEED) && !abort;
            e_beat = e_ready && in_valid;
            e_ce = '0;
            e_ce[0] = e_beat;
            if (!e_kill)
                for (int k = 1; k < PL; k++)
                    foreach (bq[i]) if (bq[i] == cyc - k) e_ce[k] = 1'b1;
            chk("in_ready", in_ready, e_ready);
            chk("stage_ce", stage_ce, e_ce);
            chk("busy", busy, m_phase != PH_IDLE);
            chk("rstp", rstp, (m_phase == PH_CLEAR) || e_kill);
            chk("result_valid", result_valid, m_phase == PH_FIN);
            chk("done", done, (m_phase == PH_FIN) || m_dz);
            if (m_phase != PH_FIN) chk("opmode", opmode, act ? 8'h09 : 8'h00);
            if (m_phase == PH_FIN) begin
                chk("p_sum", p, m_sum);
                n_rv++;
            end
        end
        @(posedge clk);
        if (!reset_n) begin
            m_phase = PH_IDLE;
            m_rem = 0;
            m_dz = 0;
            bq.delete();
        end else begin
            m_dz = 0;
            case (m_phase)
                PH_IDLE: begin
                    m_dz = start && (len == 0);
                    if (start && len != 0) begin
                        m_rem = int'(len);
                        m_phase = PH_CLEAR;
                        m_sum = 0;
                        bq.delete();
                    end
                end
                PH_CLEAR: m_phase = PH_FEED;
                PH_FEED: if (e_beat) begin
                    bq.push_back(cyc);
                    m_sum += 32'(a) * 32'(b);
                    m_last = cyc;
                    m_rem--;
                    if (m_rem == 0) m_phase = PH_DRAIN;
                end
                PH_DRAIN: if (cyc >= m_last + PL - 1) m_phase = PH_FIN;
                default: m_phase = PH_IDLE;
            endcase
            if (e_kill) begin
                m_phase = PH_IDLE;
                m_rem = 0;
                bq.delete();
            end
        end
        while (bq.size() > 0 && bq[0] < cyc - PL) void'(bq.pop_front());
        cyc++;
    end

    // One job from a negedge: cycle c drives in_valid=vmask[c]; sample (2c-2, 2c-1) on A/B.
    task automatic run_job(input int L, input logic [31:0] vmask, input int abort_c,
                           input int start2_c, input int ncyc,
                           output int done_c, output int rv_c, output logic [31:0] p_rv);
        done_c = -1;
        rv_c = -1;
        p_rv = '0;
        for (int c = 0; c < ncyc; c++) begin
            start = (c == 0) || (c == start2_c);
            len = (c == 0) ? CW'(L) : CW'(7);
            in_valid = vmask[c];
            abort = (c == abort_c);
            a = 8'(2 * c - 2);
            b = 8'(2 * c - 1);
            #1;
            if (done && done_c < 0) done_c = c;
            if (result_valid && rv_c < 0) begin
                rv_c = c;
                p_rv = p;
            end
            @(negedge clk);
        end
        start = 0;
        abort = 0;
        in_valid = 0;
    endtask

    initial begin
        int dc, rc;
        logic [31:0] pr;
        int rv_before;
        repeat (3) @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        // Uninterrupted len=3: (2*3)+(4*5)+(6*7)=68 at cycle 8.
        run_job(3, 32'hFFFF_FFFF, -1, -1, 12, dc, rc, pr);
        chk("t1_done_cycle", dc, 8);
        chk("t1_rv_cycle", rc, 8);
        chk("t1_p", pr, 68);

        // Bubble at cycle 3: beats 2,4,5 -> 6+42+72=120 at cycle 9.
        run_job(3, 32'hFFFF_FFF7, -1, -1, 12, dc, rc, pr);
        chk("t2_done_cycle", dc, 9);
        chk("t2_p", pr, 120);

        // len=0 completes immediately with no result.
        run_job(0, 32'hFFFF_FFFF, -1, -1, 4, dc, rc, pr);
        chk("t3_done_cycle", dc, 1);
        chk("t3_rv_cycle", rc, -1);

        // Abort on second beat, then a fresh len=2 job: 6+20=26.
        run_job(5, 32'hFFFF_FFFF, 3, -1, 8, dc, rc, pr);
        chk("t4_abort_done", dc, -1);
        chk("t4_abort_rv", rc, -1);
        run_job(2, 32'hFFFF_FFFF, -1, -1, 10, dc, rc, pr);
        chk("t4_done_cycle", dc, 7);
        chk("t4_p", pr, 26);

        // start during DRAIN is ignored.
        run_job(2, 32'hFFFF_FFFF, -1, 5, 12, dc, rc, pr);
        chk("t5_done_cycle", dc, 7);
        chk("t5_p", pr, 26);

        // Asynchronous reset mid-FEED.
        start = 1; len = CW'(4); in_valid = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        @(negedge clk);
        #3 reset_n = 0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_in_ready", in_ready, 0);
        chk("t6_stage_ce", stage_ce, 0);
        chk("t6_opmode", opmode, 0);
        chk("t6_rstp", rstp, 0);
        chk("t6_done", done, 0);
        @(negedge clk);
        reset_n = 1;
        in_valid = 0;
        @(negedge clk);
        run_job(3, 32'hFFFF_FFFF, -1, -1, 12, dc, rc, pr);
        chk("t6_done_cycle", dc, 8);
        chk("t6_p", pr, 68);

        // Randomized traffic against the model.
        rv_before = n_rv;
        repeat (3000) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            len = CW'($urandom_range(0, 6));
            abort = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            a = 8'($urandom);
            b = 8'($urandom);
        end
        @(negedge clk);
        start = 0;
        abort = 0;
        in_valid = 0;
        repeat (20) @(negedge clk);
        #3;
        chk("rand_results_seen", (n_rv - rv_before) > 20, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
